// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single data-memory port between two requesters. Master 0 is the
// CPU load/store path, master 1 is the I/O / DMA engine. A round-robin
// arbiter picks a winner in IDLE and latches its command. A fixed-length
// ACCESS phase then drives the memory strobes for WAIT cycles. A DONE cycle
// returns a one-cycle acknowledge to the winner.
//
// Parameters
//   DW    data width of masters and memory
//   AW    address width
//   WAIT  cycles mem_cs is held per access (1..15)
//
// Ports
//   sys_clk            system clock, rising edge
//   reset              synchronous, active-high reset
//   m0_req / m1_req    access request, held until the matching ack
//   m0_wr  / m1_wr     1 = write, 0 = read
//   m0_addr / m1_addr  request address
//   m0_wdata/ m1_wdata write data
//   m0_rdata/ m1_rdata last read data returned to that master
//   m0_ack / m1_ack    one-cycle completion pulse
//   mem_cs, mem_rd, mem_wr  memory strobes (active only in ACCESS)
//   mem_addr, mem_din  latched address / write data toward memory
//   mem_dout           read data from memory
//   busy               high while an access is in ACCESS or DONE
//   owner              master currently or most recently granted
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 12,
  parameter int WAIT = 1
) (
  input  logic          sys_clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,

  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,

  output logic          mem_cs,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,

  output logic          busy,
  output logic          owner
);

  // The counter holds WAIT-1 at grant and counts down to 0. Four bits
  // cover the whole legal WAIT range.
  localparam int         CNT_W    = 4;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             owner_q,   owner_d;
  logic             lastGnt_q, lastGnt_d;
  logic             wr_q,      wr_d;
  logic [AW-1:0]    addr_q,    addr_d;
  logic [DW-1:0]    wdata_q,   wdata_d;
  logic [DW-1:0]    rdata0_q,  rdata0_d;
  logic [DW-1:0]    rdata1_q,  rdata1_d;

  // Winner of the current IDLE cycle. Only meaningful when anyReq is high.
  logic anyReq;
  logic gntSel;

  // Round robin: a lone requester always wins. On a tie, the master that
  // was not granted last wins. lastGnt resets to 1, so master 0 takes the
  // first tie.
  always_comb begin
    anyReq = m0_req | m1_req;
    if (m0_req && m1_req) begin
      gntSel = ~lastGnt_q;
    end else begin
      gntSel = m1_req;
    end
  end

  // Next-state logic. On a grant, the chosen master's command is snapshotted
  // so that the requester may change or drop its inputs during the access
  // without disturbing it. Read data is captured on the final ACCESS cycle.
  // It is therefore already valid in the DONE (ack) cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    lastGnt_d = lastGnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d   = gntSel;
          lastGnt_d = gntSel;
          cnt_d     = CNT_LOAD;
          state_d   = ACCESS;
          if (gntSel) begin
            wr_d    = m1_wr;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            wr_d    = m0_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (owner_q) begin
              rdata1_d = mem_dout;
            end else begin
              rdata0_d = mem_dout;
            end
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any access in flight. It
  // returns every register to its idle value, including the read-data
  // registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      lastGnt_q <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      lastGnt_q <= lastGnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Strobes and acks are decoded from the registered state, so they are
  // glitch-free. They drop the cycle after a reset. The address and write
  // data always come from the latch, so they hold outside ACCESS.
  always_comb begin
    mem_cs   = (state_q == ACCESS);
    mem_rd   = (state_q == ACCESS) & ~wr_q;
    mem_wr   = (state_q == ACCESS) &  wr_q;
    mem_addr = addr_q;
    mem_din  = wdata_q;
    m0_ack   = (state_q == DONE) & ~owner_q;
    m1_ack   = (state_q == DONE) &  owner_q;
    m0_rdata = rdata0_q;
    m1_rdata = rdata1_q;
    busy     = (state_q != IDLE);
    owner    = owner_q;
  end

endmodule
